// File: rtl/dmem_dump_reader.sv
// dmem_dump_reader: walks a word-aligned range of data memory after a run
// and streams each 32-bit word, tagged with its byte address, over a
// valid/ready interface. It drives the data-memory port only while busy.
module dmem_dump_reader #(
   parameter int          ADDR_W    = 9,
   parameter int          CNT_W     = 8,
   parameter logic [1:0]  SIZE_WORD = 2'b10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [CNT_W-1:0]  word_count,
   output logic              mem_enable,
   output logic              mem_rw,
   output logic [1:0]        mem_size,
   output logic              mem_se,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [31:0]       mem_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_data,
   output logic [ADDR_W-1:0] out_addr,
   output logic              busy,
   output logic              done,
   output logic              err
);

   typedef enum logic [1:0] {IDLE, READ, PRESENT, FINISH} state_t;

   state_t            state, state_n;
   logic [ADDR_W-1:0] addr, addr_n;
   logic [CNT_W-1:0]  rem, rem_n;
   logic              reject;
   logic              accept;

   assign accept = out_valid & out_ready;

   // Next-state, next-address and remaining-word computation.
   always_comb begin
      state_n = state;
      addr_n  = addr;
      rem_n   = rem;
      reject  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if (base_addr[1:0] != 2'b00) begin
                  reject = 1'b1;
               end else if (word_count == '0) begin
                  state_n = FINISH;
               end else begin
                  addr_n  = base_addr;
                  rem_n   = word_count;
                  state_n = READ;
               end
            end
         end
         READ: state_n = PRESENT;
         PRESENT: begin
            if (accept) begin
               // Address wraps naturally at the top of the byte space.
               addr_n  = addr + ADDR_W'(4);
               rem_n   = rem - CNT_W'(1);
               state_n = (rem == CNT_W'(1)) ? FINISH : READ;
            end
         end
         FINISH: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // State, address and counter registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
         addr  <= '0;
         rem   <= '0;
      end else begin
         state <= state_n;
         addr  <= addr_n;
         rem   <= rem_n;
      end
   end

   // Memory-port and status outputs are registered from the next state so
   // that out_ready never reaches them combinationally.
   always_ff @(posedge clk) begin
      if (!reset) begin
         mem_enable <= 1'b0;
         mem_rw     <= 1'b0;
         mem_size   <= 2'b00;
         mem_se     <= 1'b0;
         mem_addr   <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         mem_enable <= (state_n == READ);
         mem_rw     <= 1'b0;
         mem_size   <= (state_n == READ) ? SIZE_WORD : 2'b00;
         mem_se     <= 1'b0;
         mem_addr   <= (state_n == READ) ? addr_n : '0;
         busy       <= (state_n == READ) || (state_n == PRESENT);
         done       <= (state_n == FINISH);
         err        <= reject;
      end
   end

   // Capture the word at the end of READ and hold it until accepted.
   always_ff @(posedge clk) begin
      if (!reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_addr  <= '0;
      end else if (state == READ) begin
         out_valid <= 1'b1;
         out_data  <= mem_data;
         out_addr  <= addr;
      end else if (accept) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_dmem_dump_reader.sv
// Directed bench for dmem_dump_reader with a big-endian byte memory model.
module tb_dmem_dump_reader;

   localparam int ADDR_W = 9;
   localparam int CNT_W  = 8;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic [CNT_W-1:0]  word_count;
   logic              mem_enable, mem_rw, mem_se;
   logic [1:0]        mem_size;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_data;
   logic              out_valid, out_ready;
   logic [31:0]       out_data;
   logic [ADDR_W-1:0] out_addr;
   logic              busy, done, err;

   logic [7:0] mem [0:511];
   int vectors = 0;
   int miscompares = 0;
   int en_cnt = 0;
   int done_cnt = 0;

   always #5 clk = ~clk;

   dmem_dump_reader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .SIZE_WORD(2'b10)) dut (
      .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
      .word_count(word_count), .mem_enable(mem_enable), .mem_rw(mem_rw),
      .mem_size(mem_size), .mem_se(mem_se), .mem_addr(mem_addr),
      .mem_data(mem_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_addr(out_addr), .busy(busy), .done(done),
      .err(err)
   );

   // Combinational big-endian read with byte-address wrap.
   always_comb begin
      mem_data = {mem[mem_addr], mem[ADDR_W'(mem_addr + 9'd1)],
                  mem[ADDR_W'(mem_addr + 9'd2)], mem[ADDR_W'(mem_addr + 9'd3)]};
   end

   always @(negedge clk) begin
      if (mem_enable) en_cnt <= en_cnt + 1;
      if (done) done_cnt <= done_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present start for one edge; returns one cycle after the edge.
   task automatic start_dump(input logic [ADDR_W-1:0] b, input logic [CNT_W-1:0] c);
      start = 1'b1;
      base_addr = b;
      word_count = c;
      tick();
      start = 1'b0;
   endtask

   function automatic logic [31:0] ctl_vec();
      return {16'd0, mem_enable, mem_rw, mem_size, mem_se, out_valid, busy, done, err, 7'd0};
   endfunction

   int en0, dn0;
   bit seen;

   initial begin
      for (int i = 0; i < 512; i++) mem[i] = 8'h00;
      mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03; mem[3] = 8'h04;
      mem[4] = 8'hA0; mem[5] = 8'hB0; mem[6] = 8'hC0; mem[7] = 8'hD0;
      mem[508] = 8'h11; mem[509] = 8'h22; mem[510] = 8'h33; mem[511] = 8'h44;

      reset = 1'b0; start = 1'b0; base_addr = '0; word_count = '0; out_ready = 1'b0;
      tick(); tick();
      chk("reset_ctl", ctl_vec(), 32'd0);
      chk("reset_maddr", 32'(mem_addr), 32'd0);
      chk("reset_odata", out_data, 32'd0);
      reset = 1'b1;
      tick();

      // Basic two-word dump, consumer always ready.
      out_ready = 1'b1;
      en0 = en_cnt;
      start_dump(9'd0, 8'd2);
      chk("t1_rd0_en", {31'd0, mem_enable}, 32'd1);
      chk("t1_rd0_size", 32'(mem_size), 32'd2);
      chk("t1_rd0_addr", 32'(mem_addr), 32'd0);
      chk("t1_busy", {31'd0, busy}, 32'd1);
      tick();
      chk("t1_w0_valid", {31'd0, out_valid}, 32'd1);
      chk("t1_w0_data", out_data, 32'h01020304);
      chk("t1_w0_addr", 32'(out_addr), 32'd0);
      chk("t1_w0_en", {31'd0, mem_enable}, 32'd0);
      tick();
      chk("t1_rd1_addr", 32'(mem_addr), 32'd4);
      chk("t1_rd1_valid", {31'd0, out_valid}, 32'd0);
      tick();
      chk("t1_w1_data", out_data, 32'hA0B0C0D0);
      chk("t1_w1_addr", 32'(out_addr), 32'd4);
      tick();
      chk("t1_done", {31'd0, done, busy, out_valid}, 32'b100);
      tick();
      chk("t1_done_gone", {31'd0, done}, 32'd0);
      chk("t1_en_cycles", 32'(en_cnt - en0), 32'd2);

      // Back-pressure: consumer stalls for 5 cycles.
      out_ready = 1'b0;
      en0 = en_cnt;
      start_dump(9'd0, 8'd2);
      tick();
      for (int k = 0; k < 5; k++) begin
         chk("t2_hold_data", out_data, 32'h01020304);
         chk("t2_hold_ctl", {30'd0, out_valid, mem_enable}, 32'b10);
         tick();
      end
      out_ready = 1'b1;
      tick();
      chk("t2_rd1_addr", 32'(mem_addr), 32'd4);
      tick();
      chk("t2_w1_data", out_data, 32'hA0B0C0D0);
      tick();
      chk("t2_done", {31'd0, done}, 32'd1);
      tick();
      chk("t2_en_cycles", 32'(en_cnt - en0), 32'd2);

      // Address wrap 508 -> 0.
      start_dump(9'd508, 8'd2);
      chk("t3_rd0_addr", 32'(mem_addr), 32'd508);
      tick();
      chk("t3_w0_data", out_data, 32'h11223344);
      chk("t3_w0_addr", 32'(out_addr), 32'd508);
      tick();
      chk("t3_rd1_addr", 32'(mem_addr), 32'd0);
      tick();
      chk("t3_w1_data", out_data, 32'h01020304);
      chk("t3_w1_addr", 32'(out_addr), 32'd0);
      tick();
      chk("t3_done", {31'd0, done}, 32'd1);
      tick();

      // Misaligned start is rejected.
      start_dump(9'd6, 8'd1);
      chk("t4_err", ctl_vec(), 32'h00000080);
      tick();
      chk("t4_err_gone", ctl_vec(), 32'd0);

      // Zero-length dump: done with no memory access.
      en0 = en_cnt;
      dn0 = done_cnt;
      start_dump(9'd0, 8'd0);
      seen = 1'b0;
      for (int k = 0; k < 4 && !seen; k++) begin
         if (done) seen = 1'b1;
         else tick();
      end
      chk("t4_zero_done", {31'd0, seen}, 32'd1);
      tick(); tick();
      chk("t4_zero_pulses", 32'(done_cnt - dn0), 32'd1);
      chk("t4_zero_noread", 32'(en_cnt - en0), 32'd0);

      // Reset while a word is held.
      out_ready = 1'b0;
      start_dump(9'd0, 8'd4);
      tick();
      chk("t5_present", {31'd0, out_valid}, 32'd1);
      dn0 = done_cnt;
      reset = 1'b0;
      tick();
      chk("t5_rst_ctl", ctl_vec(), 32'd0);
      chk("t5_rst_data", out_data, 32'd0);
      chk("t5_rst_addr", 32'(out_addr), 32'd0);
      reset = 1'b1;
      tick(); tick();
      chk("t5_no_done", 32'(done_cnt - dn0), 32'd0);
      out_ready = 1'b1;
      start_dump(9'd0, 8'd1);
      tick();
      chk("t5_fresh_data", out_data, 32'h01020304);
      tick();
      chk("t5_fresh_done", {31'd0, done}, 32'd1);
      tick();

      // Start while busy is ignored.
      start_dump(9'd0, 8'd2);
      start = 1'b1; base_addr = 9'd100; word_count = 8'd1;
      tick();
      start = 1'b0;
      chk("t6_w0_addr", 32'(out_addr), 32'd0);
      tick();
      chk("t6_rd1_addr", 32'(mem_addr), 32'd4);
      tick();
      chk("t6_w1_addr", 32'(out_addr), 32'd4);
      chk("t6_w1_data", out_data, 32'hA0B0C0D0);
      tick();
      chk("t6_done", {31'd0, done}, 32'd1);
      tick();
      chk("t6_idle", ctl_vec(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
